// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM encoding for the ALU issue/writeback controller.
// Also holds the opcode-to-flag routing helpers used at writeback.
package alu_pkg;

  localparam logic [3:0] OP_NOP        = 4'd0;
  localparam logic [3:0] OP_ADD        = 4'd1;
  localparam logic [3:0] OP_ADD_CARRY  = 4'd2;
  localparam logic [3:0] OP_SUB        = 4'd3;
  localparam logic [3:0] OP_INC        = 4'd4;
  localparam logic [3:0] OP_DEC        = 4'd5;
  localparam logic [3:0] OP_AND        = 4'd6;
  localparam logic [3:0] OP_NOT        = 4'd7;
  localparam logic [3:0] OP_ROL        = 4'd8;
  localparam logic [3:0] OP_ROR        = 4'd9;
  localparam logic [3:0] OP_LAST_VALID = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  // Subtract-type ops report their carry flag through the ALU borrow output.
  function automatic logic op_takes_borrow(input logic [3:0] op);
    return (op == OP_SUB) || (op == OP_DEC);
  endfunction

  function automatic logic op_takes_carry(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_ADD_CARRY) || (op == OP_INC) ||
           (op == OP_NOT) || (op == OP_ROL) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction valid/ready channel into the ALU issue controller.
interface alu_issue_ctrl_if #(
  parameter int BUS_WIDTH = 8,
  parameter int REG_AW    = 2
);
  logic                 instr_valid;
  logic                 instr_ready;
  logic [3:0]           instr_opcode;
  logic [REG_AW-1:0]    instr_rd;
  logic [REG_AW-1:0]    instr_rs1;
  logic [REG_AW-1:0]    instr_rs2;
  logic                 instr_imm_en;
  logic [BUS_WIDTH-1:0] instr_imm;

  modport master (
    output instr_valid, instr_opcode, instr_rd, instr_rs1, instr_rs2,
           instr_imm_en, instr_imm,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, instr_opcode, instr_rd, instr_rs1, instr_rs2,
           instr_imm_en, instr_imm,
    output instr_ready
  );
endinterface

// File: rtl/alu_regfile.sv
// Small register file: one write port, three combinational read ports (rs1, rs2, debug).
module alu_regfile #(
  parameter int  BUS_WIDTH = 8,
  parameter int  NUM_REGS  = 4,
  localparam int REG_AW    = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [REG_AW-1:0]    waddr,
  input  logic [BUS_WIDTH-1:0] wdata,
  input  logic [REG_AW-1:0]    rs1_addr,
  output logic [BUS_WIDTH-1:0] rs1_data,
  input  logic [REG_AW-1:0]    rs2_addr,
  output logic [BUS_WIDTH-1:0] rs2_data,
  input  logic [REG_AW-1:0]    dbg_addr,
  output logic [BUS_WIDTH-1:0] dbg_data
);

  logic [BUS_WIDTH-1:0] regs_r [NUM_REGS];

  // Storage array with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {BUS_WIDTH{1'b0}};
      end
    end else if (we) begin
      regs_r[waddr] <= wdata;
    end
  end

  assign rs1_data = regs_r[rs1_addr];
  assign rs2_data = regs_r[rs2_addr];
  assign dbg_data = regs_r[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller wrapped around a combinational 8-bit ALU.
// One instruction per three cycles: accept (IDLE), capture (EXEC), writeback (WB).
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int  BUS_WIDTH = 8,
  parameter int  NUM_REGS  = 4,
  localparam int REG_AW    = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_issue_ctrl_if.slave      instr,
  input  logic                 err_clr,
  output logic [3:0]           alu_opcode,
  output logic [BUS_WIDTH-1:0] alu_a,
  output logic [BUS_WIDTH-1:0] alu_b,
  output logic                 alu_carry_in,
  input  logic [BUS_WIDTH-1:0] alu_y,
  input  logic                 alu_carry_out,
  input  logic                 alu_borrow,
  input  logic                 alu_zero,
  input  logic                 alu_parity,
  input  logic                 alu_invalid_op,
  output logic                 flag_c,
  output logic                 flag_z,
  output logic                 flag_p,
  output logic                 flag_err,
  output logic                 busy,
  input  logic [REG_AW-1:0]    dbg_addr,
  output logic [BUS_WIDTH-1:0] dbg_data
);

  state_e               state_r, next_state_s;
  logic                 ready_r, busy_r;
  logic [3:0]           op_r;
  logic [BUS_WIDTH-1:0] a_r, b_r, imm_r, y_r;
  logic [REG_AW-1:0]    rd_r;
  logic                 cin_r, imm_en_r;
  logic                 carry_r, borrow_r, zero_r, parity_r, inv_r;
  logic                 c_r, z_r, p_r, err_r;
  logic [BUS_WIDTH-1:0] rs1_data_s, rs2_data_s, wb_data_s;
  logic                 accept_s, wb_we_s, c_s, z_s, p_s, err_s;

  alu_regfile #(.BUS_WIDTH(BUS_WIDTH), .NUM_REGS(NUM_REGS)) u_regfile (
    .clk(clk), .rst(rst), .we(wb_we_s), .waddr(rd_r), .wdata(wb_data_s),
    .rs1_addr(instr.instr_rs1), .rs1_data(rs1_data_s),
    .rs2_addr(instr.instr_rs2), .rs2_data(rs2_data_s),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  assign accept_s = (state_r == ST_IDLE) && instr.instr_valid;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= next_state_s;
  end

  // Next-state logic and writeback/flag decode for the WB cycle.
  always_comb begin
    next_state_s = state_r;
    wb_we_s      = 1'b0;
    wb_data_s    = y_r;
    c_s          = c_r;
    z_s          = z_r;
    p_s          = p_r;
    err_s        = err_clr ? 1'b0 : err_r;
    case (state_r)
      ST_IDLE: begin
        if (instr.instr_valid) next_state_s = ST_EXEC;
        else                   next_state_s = ST_IDLE;
      end
      ST_EXEC: next_state_s = ST_WB;
      ST_WB: begin
        next_state_s = ST_IDLE;
        // Opcode 0 never looks at the ALU, so a spurious invalid_op on it is ignored.
        if (op_r == OP_NOP) begin
          wb_we_s   = imm_en_r;
          wb_data_s = imm_r;
        end else if ((op_r > OP_LAST_VALID) || inv_r) begin
          err_s = 1'b1;
        end else begin
          wb_we_s = 1'b1;
          z_s     = zero_r;
          p_s     = parity_r;
          if (op_takes_borrow(op_r))     c_s = borrow_r;
          else if (op_takes_carry(op_r)) c_s = carry_r;
          else                           c_s = c_r;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Operand issue, ALU result capture and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_r  <= 1'b1;
      busy_r   <= 1'b0;
      op_r     <= 4'd0;
      a_r      <= {BUS_WIDTH{1'b0}};
      b_r      <= {BUS_WIDTH{1'b0}};
      cin_r    <= 1'b0;
      rd_r     <= {REG_AW{1'b0}};
      imm_r    <= {BUS_WIDTH{1'b0}};
      imm_en_r <= 1'b0;
      y_r      <= {BUS_WIDTH{1'b0}};
      carry_r  <= 1'b0;
      borrow_r <= 1'b0;
      zero_r   <= 1'b0;
      parity_r <= 1'b0;
      inv_r    <= 1'b0;
      c_r      <= 1'b0;
      z_r      <= 1'b0;
      p_r      <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      ready_r <= (next_state_s == ST_IDLE);
      busy_r  <= (next_state_s != ST_IDLE);
      if (accept_s) begin
        op_r     <= instr.instr_opcode;
        a_r      <= rs1_data_s;
        b_r      <= instr.instr_imm_en ? instr.instr_imm : rs2_data_s;
        cin_r    <= c_r;
        rd_r     <= instr.instr_rd;
        imm_r    <= instr.instr_imm;
        imm_en_r <= instr.instr_imm_en;
      end
      if (state_r == ST_EXEC) begin
        y_r      <= alu_y;
        carry_r  <= alu_carry_out;
        borrow_r <= alu_borrow;
        zero_r   <= alu_zero;
        parity_r <= alu_parity;
        inv_r    <= alu_invalid_op;
      end
      c_r   <= c_s;
      z_r   <= z_s;
      p_r   <= p_s;
      err_r <= err_s;
    end
  end

  assign instr.instr_ready = ready_r;
  assign busy         = busy_r;
  assign alu_opcode   = op_r;
  assign alu_a        = a_r;
  assign alu_b        = b_r;
  assign alu_carry_in = cin_r;
  assign flag_c       = c_r;
  assign flag_z       = z_r;
  assign flag_p       = p_r;
  assign flag_err     = err_r;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: behavioural 8-bit ALU on the alu_* ports,
// directed scenarios followed by random instructions against an architectural model.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int BW = 8;
  localparam int NR = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          err_clr = 1'b0;
  logic [3:0]    alu_opcode;
  logic [BW-1:0] alu_a, alu_b, alu_y;
  logic          alu_carry_in, alu_carry_out, alu_borrow, alu_zero, alu_parity, alu_invalid_op;
  logic          flag_c, flag_z, flag_p, flag_err, busy;
  logic [AW-1:0] dbg_addr = 2'd0;
  logic [BW-1:0] dbg_data;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.BUS_WIDTH(BW), .REG_AW(AW)) ifc ();

  alu_issue_ctrl #(.BUS_WIDTH(BW), .NUM_REGS(NR)) dut (
    .clk(clk), .rst(rst), .instr(ifc.slave), .err_clr(err_clr),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_carry_in(alu_carry_in),
    .alu_y(alu_y), .alu_carry_out(alu_carry_out), .alu_borrow(alu_borrow),
    .alu_zero(alu_zero), .alu_parity(alu_parity), .alu_invalid_op(alu_invalid_op),
    .flag_c(flag_c), .flag_z(flag_z), .flag_p(flag_p), .flag_err(flag_err),
    .busy(busy), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  typedef struct packed {
    logic [7:0] y;
    logic       c;
    logic       bo;
    logic       z;
    logic       p;
    logic       inv;
  } alu_res_t;

  // Arithmetic behaviour of the ALU, written directly from the opcode table.
  function automatic alu_res_t ref_alu(input logic [3:0] op, input logic [7:0] a, b, input logic cin);
    alu_res_t   r;
    logic [8:0] s;
    r = '0;
    s = 9'd0;
    case (op)
      4'd1: begin s = {1'b0, a} + {1'b0, b};                 r.y = s[7:0]; r.c = s[8]; end
      4'd2: begin s = {1'b0, a} + {1'b0, b} + {8'd0, cin};   r.y = s[7:0]; r.c = s[8]; end
      4'd3: begin r.y = a - b;  r.bo = (a < b); end
      4'd4: begin s = {1'b0, a} + 9'd1;                      r.y = s[7:0]; r.c = s[8]; end
      4'd5: begin r.y = a - 8'd1; r.bo = (a == 8'd0); end
      4'd6: r.y = a & b;
      4'd7: r.y = ~a;
      4'd8: begin r.y = {a[6:0], a[7]}; r.c = a[7]; end
      4'd9: begin r.y = {a[0], a[7:1]}; r.c = a[0]; end
      default: r.inv = (op != 4'd0);
    endcase
    r.z = (r.y == 8'd0);
    r.p = ^r.y;
    return r;
  endfunction

  alu_res_t alu_now;
  always_comb begin
    alu_now        = ref_alu(alu_opcode, alu_a, alu_b, alu_carry_in);
    alu_y          = alu_now.y;
    alu_carry_out  = alu_now.c;
    alu_borrow     = alu_now.bo;
    alu_zero       = alu_now.z;
    alu_parity     = alu_now.p;
    alu_invalid_op = alu_now.inv;
  end

  // Architectural model
  logic [7:0] m_regs [NR];
  logic       m_c, m_z, m_p, m_err;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NR; i++) m_regs[i] = 8'd0;
    m_c = 1'b0; m_z = 1'b0; m_p = 1'b0; m_err = 1'b0;
  endtask

  task automatic check_flags(input string tag);
    check_val({tag, ".c"},   32'(flag_c),   32'(m_c));
    check_val({tag, ".z"},   32'(flag_z),   32'(m_z));
    check_val({tag, ".p"},   32'(flag_p),   32'(m_p));
    check_val({tag, ".err"}, 32'(flag_err), 32'(m_err));
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < NR; i++) begin
      dbg_addr = AW'(i);
      #1;
      check_val($sformatf("%s.r%0d", tag, i), 32'(dbg_data), 32'(m_regs[i]));
    end
  endtask

  // Issue one instruction, check the issued operands, the 3-cycle period and the result.
  task automatic issue(input string tag, input int op, input int rd, input int rs1, input int rs2,
                       input int ie, input int imm, input int clr);
    alu_res_t   r;
    logic [7:0] ea, eb;
    int         cyc;
    bit         got;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ifc.instr_ready) begin got = 1'b1; break; end
    end
    if (!got) begin
      check_val({tag, ".ready_wait"}, 32'd0, 32'd1);
      return;
    end
    ea = m_regs[rs1];
    eb = (ie != 0) ? 8'(imm) : m_regs[rs2];
    r  = ref_alu(4'(op), ea, eb, m_c);
    ifc.instr_opcode = 4'(op);
    ifc.instr_rd     = AW'(rd);
    ifc.instr_rs1    = AW'(rs1);
    ifc.instr_rs2    = AW'(rs2);
    ifc.instr_imm_en = (ie != 0);
    ifc.instr_imm    = 8'(imm);
    ifc.instr_valid  = 1'b1;
    err_clr          = (clr != 0);
    @(posedge clk);
    #1 ifc.instr_valid = 1'b0;
    cyc = 1;
    @(negedge clk);
    check_val({tag, ".busy"},   32'(busy),         32'd1);
    check_val({tag, ".opcode"}, 32'(alu_opcode),   32'(op));
    check_val({tag, ".a"},      32'(alu_a),        32'(ea));
    check_val({tag, ".b"},      32'(alu_b),        32'(eb));
    check_val({tag, ".cin"},    32'(alu_carry_in), 32'(m_c));
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (ifc.instr_ready) begin got = 1'b1; break; end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    if (!got) check_val({tag, ".done_wait"}, 32'd0, 32'd1);
    check_val({tag, ".period"}, 32'(cyc), 32'd3);
    err_clr = 1'b0;
    if (op == 0) begin
      if (ie != 0) m_regs[rd] = 8'(imm);
      if (clr != 0) m_err = 1'b0;
    end else if (op >= 10) begin
      m_err = 1'b1;
    end else begin
      m_regs[rd] = r.y;
      m_z = r.z;
      m_p = r.p;
      if (op == 3 || op == 5) m_c = r.bo;
      else if (op != 6)       m_c = r.c;
      if (clr != 0) m_err = 1'b0;
    end
    dbg_addr = AW'(rd);
    #1;
    check_val({tag, ".rd"}, 32'(dbg_data), 32'(m_regs[rd]));
    check_flags(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    ifc.instr_valid  = 1'b0;
    ifc.instr_opcode = 4'd0;
    ifc.instr_rd     = 2'd0;
    ifc.instr_rs1    = 2'd0;
    ifc.instr_rs2    = 2'd0;
    ifc.instr_imm_en = 1'b0;
    ifc.instr_imm    = 8'd0;
    model_clear();

    // 1: reset state
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check_val("rst.ready", 32'(ifc.instr_ready), 32'd1);
    check_val("rst.busy",  32'(busy),            32'd0);
    check_flags("rst");
    check_all_regs("rst");

    // 2: LDI, LDI, ADD
    issue("ldi_r1", OP_NOP, 1, 0, 0, 1, 9, 0);
    issue("ldi_r2", OP_NOP, 2, 0, 0, 1, 33, 0);
    issue("add_r3", OP_ADD, 3, 1, 2, 0, 0, 0);

    // 3: carry out, then add-with-carry
    issue("ldi_200", OP_NOP, 1, 0, 0, 1, 200, 0);
    issue("add_ovf", OP_ADD, 0, 1, 0, 1, 100, 0);
    issue("ldi_1",   OP_NOP, 2, 0, 0, 1, 1, 0);
    issue("adc",     OP_ADD_CARRY, 3, 2, 0, 1, 1, 0);

    // 4: borrow and zero
    issue("ldi_65",  OP_NOP, 1, 0, 0, 1, 65, 0);
    issue("sub_neg", OP_SUB, 2, 1, 0, 1, 66, 0);
    issue("sub_0",   OP_SUB, 2, 1, 0, 1, 65, 0);

    // 5: invalid opcode, sticky error, clear; then set wins over clear
    issue("op12",     12, 3, 1, 2, 0, 0, 0);
    issue("add_err",  OP_ADD, 0, 1, 2, 0, 0, 0);
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    m_err = 1'b0;
    check_val("errclr.err", 32'(flag_err), 32'd0);
    issue("op15_clr", 15, 2, 0, 0, 0, 0, 1);

    // 6: reset while in EXEC aborts the instruction
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ifc.instr_ready) begin got = 1'b1; break; end
    end
    if (!got) check_val("abort.ready_wait", 32'd0, 32'd1);
    ifc.instr_opcode = OP_ADD;
    ifc.instr_rd     = 2'd1;
    ifc.instr_rs1    = 2'd1;
    ifc.instr_imm_en = 1'b1;
    ifc.instr_imm    = 8'd5;
    ifc.instr_valid  = 1'b1;
    @(posedge clk);
    #1 ifc.instr_valid = 1'b0;
    @(negedge clk);
    check_val("abort.busy_exec", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    model_clear();
    check_val("abort.ready", 32'(ifc.instr_ready), 32'd1);
    check_val("abort.busy",  32'(busy),            32'd0);
    repeat (3) @(negedge clk);
    check_val("abort.ready2", 32'(ifc.instr_ready), 32'd1);
    check_all_regs("abort");
    check_flags("abort");

    // Random instruction stream
    for (int n = 0; n < 60; n++) begin
      int op;
      op = ($urandom_range(0, 5) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
      issue($sformatf("rnd%0d", n), op, int'($urandom_range(0, NR - 1)),
            int'($urandom_range(0, NR - 1)), int'($urandom_range(0, NR - 1)),
            int'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
            ($urandom_range(0, 5) == 0) ? 1 : 0);
    end
    check_all_regs("final");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Issue/writeback controller that sits directly upstream of the 8-bit ALU.
- Accepts instructions over a valid/ready handshake and reads operands from a small internal register file.
- Drives the ALU's opcode, a, b and carry_in inputs, then captures y and the flags and writes the result back.
- Turns the purely combinational ALU into a serialized, programmable datapath for the team's CPU-style exercises.

Parameters:
- BUS_WIDTH, 8, data width; must match the ALU instance.
- NUM_REGS, 4, register-file depth. Power of two, at least 2. REG_AW = log2(NUM_REGS) is derived.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction present
- instr_ready  out  1  controller can accept an instruction
- instr_opcode  in  4  ALU opcode; 0 is handled internally
- instr_rd  in  REG_AW  destination register
- instr_rs1  in  REG_AW  source for ALU a
- instr_rs2  in  REG_AW  source for ALU b
- instr_imm_en  in  1  b comes from instr_imm instead of rs2
- instr_imm  in  BUS_WIDTH  immediate operand
- err_clr  in  1  clears the sticky flag_err
- alu_opcode  out  4  to ALU opcode
- alu_a  out  BUS_WIDTH  to ALU a
- alu_b  out  BUS_WIDTH  to ALU b
- alu_carry_in  out  1  to ALU carry_in
- alu_y  in  BUS_WIDTH  from ALU y
- alu_carry_out  in  1  from ALU carry_out
- alu_borrow  in  1  from ALU borrow
- alu_zero  in  1  from ALU zero
- alu_parity  in  1  from ALU parity
- alu_invalid_op  in  1  from ALU invalid_op
- flag_c  out  1  carry/borrow flag
- flag_z  out  1  zero flag
- flag_p  out  1  parity flag
- flag_err  out  1  sticky invalid-op flag
- busy  out  1  high whenever the FSM is not IDLE
- dbg_addr  in  REG_AW  debug read address
- dbg_data  out  BUS_WIDTH  combinational read of regfile[dbg_addr]

Behaviour:
Reset (synchronous, active-high):
- State goes to IDLE.
- All registers and flags are 0. alu_opcode, alu_a, alu_b and alu_carry_in are 0. busy is 0.
- rst has priority over every other input in every state.
- rst asserted in EXEC or WB aborts the instruction: no writeback and no flag update.

FSM states IDLE, EXEC, WB:
- IDLE:
  - instr_ready = 1.
  - On instr_valid & instr_ready: latch the instruction.
    - alu_opcode <= instr_opcode.
    - alu_a <= reg[rs1].
    - alu_b <= instr_imm_en ? instr_imm : reg[rs2].
    - alu_carry_in <= flag_c.
  - Next state is EXEC.
- EXEC:
  - instr_ready = 0. ALU outputs settle combinationally.
  - At the clock edge, capture alu_y and all ALU flags into internal result registers.
  - Next state is WB.
- WB: perform writeback and flag update per the opcode rules below. Next state is IDLE.
- alu_* outputs hold their last issued values until the next accept.
- Throughput is 1 instruction per 3 cycles.
- Issue-to-register-visible latency is 3 edges: the accept edge, the capture edge and the WB edge. dbg_data reflects the result in the cycle after the WB edge.

Opcode rules at WB:
- Opcode 0:
  - ALU result is ignored.
  - imm_en=1 (LDI): reg[rd] <= instr_imm (latched copy).
  - imm_en=0: NOP.
  - Flags are unchanged in both cases.
- Opcodes 1-9:
  - reg[rd] <= captured y.
  - flag_z <= zero. flag_p <= parity.
  - Opcodes 1, 2, 4, 7-9: flag_c <= carry_out.
  - Opcodes 3, 5 (SUB/DEC): flag_c <= borrow.
- Opcodes 10-15, or alu_invalid_op=1:
  - No writeback; flags c/z/p unchanged.
  - flag_err <= 1.

flag_err:
- Sticky until err_clr or rst.
- If err_clr and a new error occur in the same WB cycle, set wins.

Other rules:
- rd may equal rs1 or rs2. Operands are latched at accept, so there is no hazard.
- instr_valid while busy is ignored; the source must hold it until ready.
- All arithmetic wraps at BUS_WIDTH; widths come solely from the ALU.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams: OP_NOP=0, ADD=1, ADD_CARRY=2, SUB=3, INC=4, DEC=5, AND=6, NOT=7, ROL=8, ROR=9;
  - the FSM state encoding.
- One natural sub-module, alu_regfile: NUM_REGS x BUS_WIDTH, 1 write port, 3 combinational read ports (rs1, rs2, dbg), synchronous reset to 0.

Test Plan (bench instantiates the real ALU wired to the alu_* ports):
1. rst high 2 cycles, then low -> all dbg reads 0; flags 0; instr_ready=1 on the first cycle after release; busy=0.
2. LDI r1=9; LDI r2=33; ADD r3=r1+r2 -> dbg r3=42; flag_c=0, flag_z=0; each instruction busy for exactly 3 cycles.
3. LDI r1=200; ADD r0=r1+imm 100 -> r0=44, flag_c=1. Then LDI r2=1; ADD_CARRY r3=r2+imm 1 -> alu_carry_in=1, r3=3.
4. LDI r1=65; SUB r2=r1-imm 66 -> r2=255, flag_c=1 (borrow). Then SUB r2=r1-imm 65 -> r2=0, flag_z=1, flag_c=0.
5. Opcode 12 with rd=r3 -> r3 unchanged; flag_err=1 persists across a following valid ADD; err_clr pulse -> flag_err=0.
6. rst pulsed while in EXEC of ADD r1=r1+imm 5 -> r1 stays 0, state IDLE, instr_ready=1 on the next cycle.
